// File: rtl/frame_receiver.sv
// Start-nibble triggered serial deserializer with a single-entry valid/ready output buffer.
// Define FRAME_RX_PARITY_EN to add an even-parity bit between payload and stop bit.
module frame_receiver #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sIn,
  input  logic [3:0]        pIn,
  output logic [DATA_W-1:0] dOut,
  output logic              dValid,
  input  logic              dReady,
  output logic              frmErr,
  output logic              ovf,
  output logic              parErr
);

  // state | meaning
  // IDLE  | waiting for a fully known 0000 window; start edge captures the MSB
  // DATA  | shifting remaining payload bits in, MSB first
  // PAR   | sampling the even-parity bit (parity builds only)
  // STOP  | checking the stop bit and delivering or discarding the frame
  // HUNT  | after a framing error, waiting for the line to return to 1
  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, HUNT} state_t;

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_PEN  = CW'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dvalid_q, dvalid_d;
  logic              frm_err_q, frm_err_d;
  logic              ovf_q, ovf_d;
  logic              start_det, frame_good, consume, load;
`ifdef FRAME_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              par_err_q, par_err_d;
`endif

  always_comb begin
    // Case-equality keeps an unknown window from looking like a start.
    start_det  = (pIn === 4'b0000);
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    frm_err_d  = 1'b0;
    frame_good = 1'b0;
`ifdef FRAME_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    par_err_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_det) begin
          shreg_d = {{(DATA_W-1){1'b0}}, sIn};
          cnt_d   = CW'(1);
          state_d = DATA;
`ifdef FRAME_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      DATA: begin
        shreg_d = {shreg_q[DATA_W-2:0], sIn};
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_PEN) begin
`ifdef FRAME_RX_PARITY_EN
          state_d = PAR;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef FRAME_RX_PARITY_EN
      PAR: begin
        par_bad_d = (^shreg_q) ^ sIn;
        state_d   = STOP;
      end
`endif
      STOP: begin
`ifdef FRAME_RX_PARITY_EN
        par_err_d = par_bad_q;
`endif
        if (sIn) begin
          state_d = IDLE;
`ifdef FRAME_RX_PARITY_EN
          frame_good = ~par_bad_q;
`else
          frame_good = 1'b1;
`endif
        end else begin
          frm_err_d = 1'b1;
          state_d   = HUNT;
        end
      end
      HUNT: begin
        if (sIn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A consume on the delivery edge frees the slot for the new word.
    consume  = dvalid_q & dReady;
    load     = frame_good & (~dvalid_q | dReady);
    ovf_d    = frame_good & dvalid_q & ~dReady;
    dvalid_d = load | (dvalid_q & ~consume);
    dout_d   = load ? shreg_q : dout_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef FRAME_RX_PARITY_EN
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
`ifdef FRAME_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign dOut   = dout_q;
  assign dValid = dvalid_q;
  assign frmErr = frm_err_q;
  assign ovf    = ovf_q;
`ifdef FRAME_RX_PARITY_EN
  assign parErr = par_err_q;
`else
  assign parErr = 1'b0;
`endif

endmodule
